// File: rtl/pb_ram_arbiter_if.sv
// Signal bundle between two PicoBlaze requesters, the arbiter and a single-port byte RAM.
// master = requesters plus RAM model side, slave = arbiter side.
interface pb_ram_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              rvalid0;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              busy;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      input  ram_en, ram_we, ram_addr, ram_wdata, busy
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
      output ram_en, ram_we, ram_addr, ram_wdata, busy
   );
endinterface

// File: rtl/pb_ram_arbiter.sv
// Two-requester arbiter for one single-port RAM; round-robin on ties by default,
// fixed priority to requester 0 when PB_ARB_FIXED_PRIO_EN is defined.
module pb_ram_arbiter #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned RAM_LAT = 1
) (
   input logic             clk,
   input logic             reset_n,
   pb_ram_arbiter_if.slave bus
);
   localparam int unsigned CntW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic              id_q, id_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              pick1;

`ifdef PB_ARB_FIXED_PRIO_EN
   assign pick1 = bus.req1 & ~bus.req0;
`else
   logic last_q, last_d;

   // On a tie the requester that did not win last time goes next.
   assign pick1  = bus.req1 & (~bus.req0 | ~last_q);
   assign last_d = ((state_q == StIdle) && (bus.req0 || bus.req1)) ? pick1 : last_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req0 || bus.req1) begin
               // The RAM-side registers double as the latched request.
               id_d        = pick1;
               gnt0_d      = ~pick1;
               gnt1_d      = pick1;
               ram_en_d    = 1'b1;
               ram_we_d    = pick1 ? bus.we1 : bus.we0;
               ram_addr_d  = pick1 ? bus.addr1 : bus.addr0;
               ram_wdata_d = pick1 ? bus.wdata1 : bus.wdata0;
               state_d     = StAccess;
            end
         end
         StAccess: begin
            cnt_d   = CntW'(RAM_LAT - 1);
            state_d = ram_we_q ? StIdle : StWait;
         end
         StWait: begin
            if (cnt_q == '0) begin
               if (id_q) begin
                  rdata1_d  = bus.ram_rdata;
                  rvalid1_d = 1'b1;
               end else begin
                  rdata0_d  = bus.ram_rdata;
                  rvalid0_d = 1'b1;
               end
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         id_q        <= 1'b0;
         cnt_q       <= '0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.rvalid0   = rvalid0_q;
   assign bus.rvalid1   = rvalid1_q;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
   assign bus.ram_en    = ram_en_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_pb_ram_arbiter.sv
// Bench for pb_ram_arbiter: RAM_LAT=1 instance for most scenarios, RAM_LAT=2 instance for
// the top-address latency case; read data checked through per-requester scoreboard queues.
module tb_pb_ram_arbiter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   pb_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
   pb_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();

   pb_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LAT(1)) u_dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );
   pb_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LAT(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .bus(bus2)
   );

   // RAM models: data valid RAM_LAT edges after the address edge, zero when not a read.
   logic [7:0] mem  [256];
   logic [7:0] mem2 [256];
   logic [7:0] ref_mem [256];
   logic [7:0] p0, q0, q1;
   logic [7:0] sb0[$];
   logic [7:0] sb1[$];

   always @(posedge clk) begin
      if (bus.ram_en && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      p0 <= (bus.ram_en && !bus.ram_we) ? mem[bus.ram_addr] : 8'h00;
      if (bus2.ram_en && bus2.ram_we) mem2[bus2.ram_addr] <= bus2.ram_wdata;
      q0 <= (bus2.ram_en && !bus2.ram_we) ? mem2[bus2.ram_addr] : 8'h00;
      q1 <= q0;
   end
   assign bus.ram_rdata  = p0;
   assign bus2.ram_rdata = q1;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]  <= 8'(~i);
         mem2[i] <= 8'(~i);
         ref_mem[i] = 8'(~i);
      end
      p0 <= 8'h00;
      q0 <= 8'h00;
      q1 <= 8'h00;
   end

   // Exclusivity: one grant, one response, and ram_en only together with a grant.
   always @(negedge clk) begin
      if (reset_n) begin
         tests++;
         if ((bus.gnt0 && bus.gnt1) || (bus.rvalid0 && bus.rvalid1) ||
             (bus.ram_en != (bus.gnt0 || bus.gnt1)) ||
             (bus2.gnt0 && bus2.gnt1) || (bus2.rvalid0 && bus2.rvalid1) ||
             (bus2.ram_en != (bus2.gnt0 || bus2.gnt1))) begin
            fails++;
            $display("FAIL excl: t=%0t gnt=%b%b/%b%b rvalid=%b%b/%b%b ram_en=%b/%b, required no overlap and ram_en==gnt",
                     $time, bus.gnt0, bus.gnt1, bus2.gnt0, bus2.gnt1, bus.rvalid0, bus.rvalid1,
                     bus2.rvalid0, bus2.rvalid1, bus.ram_en, bus2.ram_en);
         end
      end
   end

   task automatic do_access(input bit id, input bit we, input logic [7:0] a,
                            input logic [7:0] d, output int glat);
      int         n;
      int         m;
      logic [7:0] other;
      logic [7:0] got;
      logic [7:0] exp;
      if (id) begin
         bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
      end else begin
         bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
      end
      n = 0;
      do begin @(negedge clk); n++; end while (!(id ? bus.gnt1 : bus.gnt0) && n < 20);
      glat = n;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      tests++;
      if (!(id ? bus.gnt1 : bus.gnt0)) begin
         fails++;
         $display("FAIL gnt_wait: no gnt%0d after %0d cycles, required within 20", id, n);
         return;
      end
      tests++;
      if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {1'b1, we, a} ||
          (we && bus.ram_wdata !== d)) begin
         fails++;
         $display("FAIL ram_side: en=%b we=%b addr=%h wdata=%h, required en=1 we=%b addr=%h wdata=%h",
                  bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, we, a, d);
      end
      if (we) begin
         ref_mem[a] = d;
         return;
      end
      if (id) sb1.push_back(ref_mem[a]);
      else    sb0.push_back(ref_mem[a]);
      other = id ? bus.rdata0 : bus.rdata1;
      m = 0;
      do begin @(negedge clk); m++; end while (!(id ? bus.rvalid1 : bus.rvalid0) && m < 20);
      tests++;
      if (m != 2) begin
         fails++;
         $display("FAIL rd_latency: rvalid%0d %0d cycles after gnt, required 2", id, m);
      end
      got = id ? bus.rdata1 : bus.rdata0;
      if (id) exp = sb1.pop_front();
      else    exp = sb0.pop_front();
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL rdata%0d: got %h, required %h (addr %h)", id, got, exp, a);
      end
      tests++;
      if ((id ? bus.rdata0 : bus.rdata1) !== other) begin
         fails++;
         $display("FAIL rdata_other: rdata%0d changed to %h, required %h",
                  !id, id ? bus.rdata0 : bus.rdata1, other);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_en, bus.ram_we, bus.busy} !== 7'b0) begin
         fails++;
         $display("FAIL reset_ctrl: gnt/rvalid/en/we/busy=%b, required 0",
                  {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_en, bus.ram_we, bus.busy});
      end
      tests++;
      if ({bus.rdata0, bus.rdata1, bus.ram_addr, bus.ram_wdata} !== 32'h0) begin
         fails++;
         $display("FAIL reset_data: rdata0/1 addr wdata=%h, required 0",
                  {bus.rdata0, bus.rdata1, bus.ram_addr, bus.ram_wdata});
      end
      reset_n = 1'b1;
   endtask

   task automatic test_write_read();
      int g;
      do_access(1'b0, 1'b1, 8'h10, 8'hA5, g);
      tests++;
      if (g != 1) begin
         fails++;
         $display("FAIL wr_gnt_latency: gnt0 after %0d cycles, required 1", g);
      end
      do_access(1'b0, 1'b0, 8'h10, 8'h00, g);
      tests++;
      if (g != 2) begin
         fails++;
         $display("FAIL rd_after_wr_gnt: gnt0 after %0d cycles, required 2", g);
      end
      tests++;
      if (bus.rdata0 !== 8'hA5 || bus.rdata1 !== 8'h00) begin
         fails++;
         $display("FAIL wr_rd_data: rdata0=%h rdata1=%h, required A5 00", bus.rdata0, bus.rdata1);
      end
   endtask

   task automatic test_reset_mid_read();
      int n;
      bit seen;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.gnt0 && n < 20);
      bus.req0 = 1'b0;
      tests++;
      if (!bus.gnt0) begin
         fails++;
         $display("FAIL mid_gnt: no gnt0 after %0d cycles, required within 20", n);
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      tests++;
      if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_en, bus.ram_we, bus.busy} !== 7'b0 ||
          {bus.rdata0, bus.rdata1, bus.ram_addr, bus.ram_wdata} !== 32'h0) begin
         fails++;
         $display("FAIL mid_reset_outputs: ctrl=%b data=%h, required all 0",
                  {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.ram_en, bus.ram_we, bus.busy},
                  {bus.rdata0, bus.rdata1, bus.ram_addr, bus.ram_wdata});
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.rvalid0 || bus.rvalid1 || bus.busy) seen = 1'b1;
      end
      tests++;
      if (seen) begin
         fails++;
         $display("FAIL mid_reset_drop: rvalid/busy seen=1 after reset, required 0");
      end
   endtask

   task automatic test_round_robin();
      int  n;
      int  k;
      bit  gid;
      bit  exp_id;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(~i);
      ref_mem[8'h10] = 8'hA5;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h02;
      n = 0;
      k = 0;
      while (n < 80 && (k < 4 || sb0.size() != 0 || sb1.size() != 0)) begin
         @(negedge clk);
         n++;
         if (bus.gnt0 || bus.gnt1) begin
            gid = bus.gnt1;
`ifdef PB_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = k[0];
`endif
            tests++;
            if (gid !== exp_id) begin
               fails++;
               $display("FAIL rr_order: grant %0d went to %0d, required %0d", k, gid, exp_id);
            end
            if (gid) sb1.push_back(ref_mem[8'h02]);
            else     sb0.push_back(ref_mem[8'h01]);
            k++;
            if (k == 4) begin
               bus.req0 = 1'b0;
               bus.req1 = 1'b0;
            end
         end
         if (bus.rvalid0) begin
            tests++;
            if (sb0.size() == 0 || bus.rdata0 !== sb0[0]) begin
               fails++;
               $display("FAIL rr_rdata0: got %h, queued=%0d", bus.rdata0, sb0.size());
            end
            if (sb0.size() != 0) void'(sb0.pop_front());
         end
         if (bus.rvalid1) begin
            tests++;
            if (sb1.size() == 0 || bus.rdata1 !== sb1[0]) begin
               fails++;
               $display("FAIL rr_rdata1: got %h, queued=%0d", bus.rdata1, sb1.size());
            end
            if (sb1.size() != 0) void'(sb1.pop_front());
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      tests++;
      if (k != 4 || sb0.size() != 0 || sb1.size() != 0) begin
         fails++;
         $display("FAIL rr_complete: grants=%0d pending=%0d/%0d, required 4 and 0/0",
                  k, sb0.size(), sb1.size());
      end
   endtask

   task automatic test_write_then_read();
      int n;
      @(negedge clk);
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h20; bus.wdata1 = 8'h3C;
      @(negedge clk);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h20;
      tests++;
      if (!(bus.gnt1 && !bus.gnt0)) begin
         fails++;
         $display("FAIL wr_first: gnt0=%b gnt1=%b, required gnt1 only", bus.gnt0, bus.gnt1);
      end
      bus.req1 = 1'b0;
      ref_mem[8'h20] = 8'h3C;
      sb0.push_back(8'h3C);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.gnt0 && n < 20);
      bus.req0 = 1'b0;
      tests++;
      if (!bus.gnt0 || n != 2) begin
         fails++;
         $display("FAIL rd_second_gnt: gnt0=%b after %0d cycles, required 1 after 2", bus.gnt0, n);
      end
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.rvalid0 && n < 20);
      tests++;
      if (!bus.rvalid0 || bus.rdata0 !== sb0[0]) begin
         fails++;
         $display("FAIL wr_rd_order: rvalid0=%b rdata0=%h, required 1 and %h",
                  bus.rvalid0, bus.rdata0, sb0[0]);
      end
      void'(sb0.pop_front());
   endtask

   task automatic test_top_addr();
      int g;
      int n;
      do_access(1'b1, 1'b1, 8'hFF, 8'hC3, g);
      do_access(1'b1, 1'b0, 8'hFF, 8'h00, g);
      // RAM_LAT=2 instance: write then read the top address.
      bus2.req0 = 1'b1; bus2.we0 = 1'b1; bus2.addr0 = 8'hFF; bus2.wdata0 = 8'h77;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus2.gnt0 && n < 20);
      bus2.req0 = 1'b0;
      tests++;
      if (!bus2.gnt0 || bus2.ram_addr !== 8'hFF || bus2.ram_wdata !== 8'h77 || !bus2.ram_we) begin
         fails++;
         $display("FAIL lat2_write: gnt0=%b addr=%h wdata=%h we=%b, required 1 FF 77 1",
                  bus2.gnt0, bus2.ram_addr, bus2.ram_wdata, bus2.ram_we);
      end
      @(negedge clk);
      bus2.req0 = 1'b1; bus2.we0 = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus2.gnt0 && n < 20);
      bus2.req0 = 1'b0;
      sb0.push_back(8'h77);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus2.rvalid0 && n < 20);
      tests++;
      if (n != 3) begin
         fails++;
         $display("FAIL lat2_latency: rvalid0 %0d cycles after gnt, required 3", n);
      end
      tests++;
      if (bus2.rdata0 !== sb0[0]) begin
         fails++;
         $display("FAIL lat2_rdata: got %h, required %h", bus2.rdata0, sb0[0]);
      end
      void'(sb0.pop_front());
   endtask

   initial begin
      bus.req0 = 1'b0;  bus.req1 = 1'b0;  bus.we0 = 1'b0;  bus.we1 = 1'b0;
      bus.addr0 = '0;   bus.addr1 = '0;   bus.wdata0 = '0; bus.wdata1 = '0;
      bus2.req0 = 1'b0; bus2.req1 = 1'b0; bus2.we0 = 1'b0; bus2.we1 = 1'b0;
      bus2.addr0 = '0;  bus2.addr1 = '0;  bus2.wdata0 = '0; bus2.wdata1 = '0;
      test_reset();
      test_write_read();
      test_reset_mid_read();
      test_round_robin();
      test_write_then_read();
      test_top_addr();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog");
   end
endmodule
